// File: rtl/usb_rx_parser.sv
// rtl/usb_rx_parser.sv - length-prefixed frame parser with XOR check and commit/rollback payload FIFO
module usb_rx_parser #(
  parameter int                   DATA_NBIT = 8,
  parameter int                   ADDR_NBIT = 9,
  parameter logic [DATA_NBIT-1:0] SYNC_BYTE = 8'hA5,
  parameter logic [15:0]          TIMEOUT   = 16'd4800
) (
  input  logic                 ifclk,
  input  logic                 rst_n,
  input  logic                 rx_cache_vd,
  input  logic [DATA_NBIT-1:0] rx_cache_data,
  input  logic                 rx_cache_sop,
  input  logic                 rx_cache_eop,
  output logic                 cmd_vd,
  output logic [7:0]           cmd_code,
  output logic [7:0]           cmd_len,
  input  logic                 pl_rd,
  output logic [DATA_NBIT-1:0] pl_data,
  output logic                 pl_empty,
  output logic                 err_vd,
  output logic [1:0]           err_type,
  output logic [7:0]           err_cnt
);

  typedef enum logic [2:0] {ST_SYNC, ST_CMD, ST_LEN, ST_PL, ST_CHK} state_t;

  localparam int CW = (ADDR_NBIT + 1 > 8) ? ADDR_NBIT + 1 : 8;
  localparam logic [ADDR_NBIT:0] DEPTH = {1'b1, {ADDR_NBIT{1'b0}}};

  state_t                 state;
  logic [ADDR_NBIT:0]     wr_ptr, commit_ptr, rd_ptr;
  logic [DATA_NBIT-1:0]   chk;
  logic [7:0]             pl_left, cmd_q, len_q;
  logic                   drop;
  logic [15:0]            idle_cnt;
  logic [DATA_NBIT-1:0]   mem [0:(1<<ADDR_NBIT)-1];

  logic [ADDR_NBIT:0]     free;
  logic                   expire, mem_we, rd_en;
  logic                   err_hit, accept;
  logic [1:0]             err_code;

  // sop/eop carry no framing meaning; frames are delimited by length alone
  logic unused_status;
  assign unused_status = rx_cache_sop ^ rx_cache_eop;

  assign free     = DEPTH - (wr_ptr - rd_ptr);
  assign pl_empty = (commit_ptr == rd_ptr);
  assign rd_en    = pl_rd && !pl_empty;
  assign expire   = (state != ST_SYNC) && (idle_cnt == TIMEOUT);
  assign mem_we   = (state == ST_PL) && rx_cache_vd && !drop && !expire;

  // Timeout outranks whatever byte arrives in the expiry cycle
  always_comb begin
    err_hit  = 1'b0;
    err_code = 2'd0;
    accept   = 1'b0;
    if (expire) begin
      err_hit  = 1'b1;
      err_code = 2'd3;
    end else if (rx_cache_vd) begin
      case (state)
        ST_SYNC: if (rx_cache_data != SYNC_BYTE) err_hit = 1'b1;
        ST_CHK: begin
          if (drop) begin
            err_hit  = 1'b1;
            err_code = 2'd2;
          end else if (rx_cache_data != chk) begin
            err_hit  = 1'b1;
            err_code = 2'd1;
          end else begin
            accept = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ifclk) begin
    if (mem_we) mem[wr_ptr[ADDR_NBIT-1:0]] <= rx_cache_data;
  end

  always_ff @(posedge ifclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      chk        <= '0;
      pl_left    <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      drop       <= 1'b0;
      idle_cnt   <= '0;
      cmd_vd     <= 1'b0;
      cmd_code   <= '0;
      cmd_len    <= '0;
      pl_data    <= '0;
      err_vd     <= 1'b0;
      err_type   <= '0;
      err_cnt    <= '0;
    end else begin
      cmd_vd <= accept;
      err_vd <= err_hit;

      if (err_hit) begin
        err_type <= err_code;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end

      if (accept) begin
        cmd_code   <= cmd_q;
        cmd_len    <= len_q;
        commit_ptr <= wr_ptr;
      end

      // Any in-frame error discards the uncommitted bytes
      if (err_hit && state != ST_SYNC) wr_ptr <= commit_ptr;
      else if (mem_we)                 wr_ptr <= wr_ptr + 1'b1;

      if (rd_en) begin
        pl_data <= mem[rd_ptr[ADDR_NBIT-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      if (state == ST_SYNC || rx_cache_vd || expire) idle_cnt <= '0;
      else if (idle_cnt != TIMEOUT)                  idle_cnt <= idle_cnt + 16'd1;

      if (expire) begin
        state <= ST_SYNC;
      end else if (rx_cache_vd) begin
        case (state)
          ST_SYNC: if (rx_cache_data == SYNC_BYTE) state <= ST_CMD;
          ST_CMD: begin
            cmd_q <= rx_cache_data[7:0];
            chk   <= rx_cache_data;
            state <= ST_LEN;
          end
          ST_LEN: begin
            len_q   <= rx_cache_data[7:0];
            pl_left <= rx_cache_data[7:0];
            chk     <= chk ^ rx_cache_data;
            drop    <= CW'(free) < CW'(rx_cache_data[7:0]);
            state   <= (rx_cache_data[7:0] == 8'd0) ? ST_CHK : ST_PL;
          end
          ST_PL: begin
            chk     <= chk ^ rx_cache_data;
            pl_left <= pl_left - 8'd1;
            if (pl_left == 8'd1) state <= ST_CHK;
          end
          ST_CHK:  state <= ST_SYNC;
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule
